// File: rtl/fmlarbn_pkg.sv
`default_nettype none
// =====================================================================
// Module  : fmlarbn_pkg
// Purpose : Shared mode constants, index type and candidate search.
// Rev     : 1.0
// =====================================================================
package fmlarbn_pkg;

  localparam int RR_FIXED0 = 0;
  localparam int RR_ALL    = 1;

  typedef logic [2:0] idx_t;

  // Request bits above nmasters are always zero, so wrapping at 8 visits
  // the live masters in the same order as wrapping at nmasters.
  function automatic idx_t next_rr(input idx_t master, input logic [7:0] req,
                                   input logic exclude, input logic skip0);
    idx_t cand;
    logic found;
    next_rr = master;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = master + idx_t'(k);
      if (!found && req[cand] && !(exclude && k == 8) && !(skip0 && cand == '0)) begin
        next_rr = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmlarbn_ack.sv
`default_nettype none
// =====================================================================
// Module  : fmlarbn_ack
// Purpose : Per-channel pending flag, read-ack delay line, masked strobe.
// Rev     : 1.0
// =====================================================================
module fmlarbn_ack #(
  parameter int rd_delay = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic m_stb_i,
  input  logic eack_i,
  input  logic we_i,
  output logic stbm_o,
  output logic ack_o
);

  logic                pend_q, pend_d;
  logic [rd_delay-1:0] rsr_q, rsr_d;

  // A write acks in the eack cycle, so its pending flag never rises.
  always_comb begin
    ack_o  = (eack_i & we_i) | rsr_q[rd_delay-1];
    pend_d = pend_q;
    if (ack_o) begin
      pend_d = 1'b0;
    end else if (eack_i) begin
      pend_d = 1'b1;
    end
    rsr_d = (rsr_q << 1) | rd_delay'(eack_i & ~we_i);
  end

  assign stbm_o = m_stb_i & ~pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      rsr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      rsr_q  <= rsr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fmlarbn.sv
`default_nettype none
// =====================================================================
// Module  : fmlarbn
// Purpose : N-master FML arbiter, priority or round-robin, run-capped.
// Rev     : 1.0
// =====================================================================
module fmlarbn
  import fmlarbn_pkg::*;
#(
  parameter int fml_depth = 26,
  parameter int nmasters  = 6,
  parameter int rr_mode   = 0,
  parameter int max_run   = 8,
  parameter int rd_delay  = 4,
  parameter int wr_beats  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [nmasters*fml_depth-1:0] m_adr,
  input  logic [nmasters-1:0]           m_stb,
  input  logic [nmasters-1:0]           m_we,
  output logic [nmasters-1:0]           m_ack,
  input  logic [nmasters*8-1:0]         m_sel,
  input  logic [nmasters*64-1:0]        m_di,
  output logic [63:0]                   m_do,
  output logic [fml_depth-1:0]          s_adr,
  output logic                          s_stb,
  output logic                          s_we,
  input  logic                          s_eack,
  output logic [7:0]                    s_sel,
  input  logic [63:0]                   s_di,
  output logic [63:0]                   s_do,
  output logic [2:0]                    grant
);

  localparam int             WCW      = (wr_beats > 1) ? $clog2(wr_beats) : 1;
  localparam logic [WCW-1:0] WLAST    = WCW'(wr_beats - 1);
  localparam logic [7:0]     RUN_LAST = 8'(max_run - 1);

  idx_t           master_q, master_d, wmaster_q, wmaster_d;
  idx_t           cand, msel, wsel;
  logic [7:0]     run_q, run_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [nmasters-1:0] stbm;
  logic [7:0]     req, we_v;
  logic           others, excl, pick0;

  // Encodings past the last master fall back to master 0.
  function automatic idx_t lim(input idx_t x);
    return (int'(x) < nmasters) ? x : '0;
  endfunction

  generate
    for (genvar i = 0; i < nmasters; i++) begin : g_ch
      fmlarbn_ack #(.rd_delay(rd_delay)) u_ack (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .m_stb_i (m_stb[i]),
        .eack_i  (s_eack & (master_q == idx_t'(i))),
        .we_i    (s_we),
        .stbm_o  (stbm[i]),
        .ack_o   (m_ack[i])
      );
    end
  endgenerate

  assign req   = 8'(stbm);
  assign we_v  = 8'(m_we);
  assign msel  = lim(master_q);
  assign wsel  = lim(wmaster_q);

  assign s_adr = m_adr[msel*fml_depth +: fml_depth];
  assign s_we  = we_v[msel];
  assign s_stb = req[msel];
  assign s_do  = m_di[wsel*64 +: 64];
  assign s_sel = m_sel[wsel*8 +: 8];
  assign m_do  = s_di;
  assign grant = master_q;

  always_comb begin
    others   = |(req & ~(8'd1 << master_q));
    excl     = s_eack & others & (run_q == RUN_LAST);
    pick0    = (rr_mode == RR_FIXED0) && req[0] && !(excl && master_q == '0);
    cand     = pick0 ? '0 : next_rr(master_q, req, excl, rr_mode == RR_FIXED0);
    master_d = (~req[master_q] | s_eack) ? cand : master_q;
    run_d    = run_q;
    if (s_eack) begin
      run_d = (master_d == master_q && others) ? run_q + 8'd1 : '0;
    end else if (master_d != master_q) begin
      run_d = '0;
    end
  end

  // Write data follows the master that owned the last write eack for the whole burst.
  always_comb begin
    wmaster_d = wmaster_q;
    wcnt_d    = wcnt_q;
    if (wcnt_q != '0) begin
      wcnt_d = wcnt_q - 1'b1;
    end else if (s_we && s_eack) begin
      wmaster_d = master_q;
      wcnt_d    = WLAST;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      master_q  <= '0;
      wmaster_q <= '0;
      run_q     <= '0;
      wcnt_q    <= '0;
    end else begin
      master_q  <= master_d;
      wmaster_q <= wmaster_d;
      run_q     <= run_d;
      wcnt_q    <= wcnt_d;
    end
  end

`ifndef SYNTHESIS
  a_wr_spacing: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (s_we && s_eack) |-> (wcnt_q == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmlarbn.sv
`default_nettype none
// =====================================================================
// Module  : tb_fmlarbn
// Purpose : Random stimulus on a priority and a round-robin arbiter,
//           checked against a cycle-time reference model.
// Rev     : 1.0
// =====================================================================
module tb_fmlarbn;

  localparam int N  = 6;
  localparam int FD = 26;
  localparam int MR = 3;
  localparam int RD = 4;
  localparam int WB = 4;
  localparam int NCYC = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*FD-1:0]   m_adr = '0;
  logic [N-1:0]      m_stb = '0;
  logic [N-1:0]      m_we = '0;
  logic [N*8-1:0]    m_sel = '0;
  logic [N*64-1:0]   m_di = '0;
  logic [63:0]       s_di = '0;
  logic              s_eack [2];
  logic [N-1:0]      m_ack  [2];
  logic [63:0]       m_do   [2];
  logic [FD-1:0]     s_adr  [2];
  logic              s_stb  [2];
  logic              s_we   [2];
  logic [7:0]        s_sel  [2];
  logic [63:0]       s_do   [2];
  logic [2:0]        grant  [2];

  // Reference state: d=0 is the fixed-priority instance, d=1 round-robin.
  int cur [2];
  int run [2];
  int wm [2];
  int wfree [2];
  int ack_at [2][N];
  int cyc;
  int n_tests = 0;
  int n_fail  = 0;
  int n_rst   = 0;

  always #5 clk = ~clk;

  fmlarbn #(.fml_depth(FD), .nmasters(N), .rr_mode(0), .max_run(MR),
            .rd_delay(RD), .wr_beats(WB)) u_fix (
    .sys_clk(clk), .sys_rst_n(rst_n), .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we),
    .m_ack(m_ack[0]), .m_sel(m_sel), .m_di(m_di), .m_do(m_do[0]), .s_adr(s_adr[0]),
    .s_stb(s_stb[0]), .s_we(s_we[0]), .s_eack(s_eack[0]), .s_sel(s_sel[0]),
    .s_di(s_di), .s_do(s_do[0]), .grant(grant[0]));

  fmlarbn #(.fml_depth(FD), .nmasters(N), .rr_mode(1), .max_run(MR),
            .rd_delay(RD), .wr_beats(WB)) u_rr (
    .sys_clk(clk), .sys_rst_n(rst_n), .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we),
    .m_ack(m_ack[1]), .m_sel(m_sel), .m_di(m_di), .m_do(m_do[1]), .s_adr(s_adr[1]),
    .s_stb(s_stb[1]), .s_we(s_we[1]), .s_eack(s_eack[1]), .s_sel(s_sel[1]),
    .s_di(s_di), .s_do(s_do[1]), .grant(grant[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit stbm_of(input int d, input int i);
    return m_stb[i] && !(ack_at[d][i] >= cyc);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cur[d] = 0; run[d] = 0; wm[d] = 0; wfree[d] = 0;
      for (int i = 0; i < N; i++) ack_at[d][i] = -1;
    end
  endtask

  // Advance one reference instance across a clock edge.
  task automatic model_step(input int d, input bit eack);
    bit sb [N];
    bit others, excl, rearb, we;
    int nxt;
    for (int i = 0; i < N; i++) sb[i] = stbm_of(d, i);
    others = 1'b0;
    for (int i = 0; i < N; i++) if (i != cur[d] && sb[i]) others = 1'b1;
    we    = m_we[cur[d]];
    excl  = eack && others && (run[d] == MR - 1);
    rearb = !sb[cur[d]] || eack;
    nxt   = cur[d];
    if (rearb) begin
      if (d == 0 && sb[0] && !(excl && cur[d] == 0)) begin
        nxt = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (cur[d] + k) % N;
          if (d == 0 && c == 0) continue;
          if (excl && c == cur[d]) continue;
          if (sb[c]) begin
            nxt = c;
            break;
          end
        end
      end
    end
    if (eack) run[d] = (nxt == cur[d] && others) ? run[d] + 1 : 0;
    else if (nxt != cur[d]) run[d] = 0;
    if (eack && !we) ack_at[d][cur[d]] = cyc + RD;
    if (eack && we) begin
      wm[d]    = cur[d];
      wfree[d] = cyc + WB;
    end
    cur[d] = nxt;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d ack", tag, d), 64'(m_ack[d]), 64'd0);
      check($sformatf("%s d%0d grant", tag, d), 64'(grant[d]), 64'd0);
      check($sformatf("%s d%0d stb", tag, d), 64'(s_stb[d]), 64'(m_stb[0]));
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (cyc < 60) begin
        m_stb[i] = (i == 0 || i == 2);
        m_we[i]  = 1'b1;
      end else if (cyc < 120) begin
        m_stb[i] = (i == 0 || i == 1 || i == 3);
        m_we[i]  = 1'b0;
      end else begin
        if ($urandom_range(3) == 0) m_stb[i] = ~m_stb[i];
        m_we[i] = ($urandom_range(2) == 0);
      end
      m_adr[i*FD +: FD] = FD'($urandom);
      m_sel[i*8 +: 8]   = 8'($urandom);
      m_di[i*64 +: 64]  = {$urandom, $urandom};
    end
    s_di = {$urandom, $urandom};
  endtask

  initial begin
    logic [N-1:0]  e_ack;
    logic [FD-1:0] e_adr;
    bit            e_stb, e_we;
    model_reset();
    cyc = 0;
    s_eack[0] = 1'b0;
    s_eack[1] = 1'b0;
    m_stb[0]  = 1'b1;
    m_we[0]   = 1'b1;
    #1;
    check_reset_outputs("reset_init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    while (cyc < NCYC) begin
      if (n_rst < 3 && cyc > 200 * (n_rst + 1) && ack_at[0][0] + 0 >= 0 &&
          ((ack_at[0][0] == cyc - 2 + RD) || (ack_at[0][1] == cyc - 2 + RD) ||
           (ack_at[0][2] == cyc - 2 + RD) || (ack_at[0][3] == cyc - 2 + RD) ||
           (ack_at[0][4] == cyc - 2 + RD) || (ack_at[0][5] == cyc - 2 + RD))) begin
        n_rst++;
        s_eack[0] = 1'b0;
        s_eack[1] = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(posedge clk); cyc++;
        #1 check_reset_outputs("reset_hold");
        @(posedge clk); cyc++;
        #1 rst_n = 1'b1;
        model_reset();
        continue;
      end

      drive_inputs();
      for (int d = 0; d < 2; d++) begin
        e_stb = stbm_of(d, cur[d]);
        e_we  = m_we[cur[d]];
        s_eack[d] = e_stb && (cyc < 120 || $urandom_range(1) == 0) &&
                    (!e_we || cyc >= wfree[d]);
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        e_stb = stbm_of(d, cur[d]);
        e_we  = m_we[cur[d]];
        e_adr = m_adr[cur[d]*FD +: FD];
        for (int i = 0; i < N; i++)
          e_ack[i] = (ack_at[d][i] == cyc) || (s_eack[d] && cur[d] == i && e_we);
        check($sformatf("d%0d c%0d grant", d, cyc), 64'(grant[d]), 64'(cur[d]));
        check($sformatf("d%0d c%0d s_stb", d, cyc), 64'(s_stb[d]), 64'(e_stb));
        check($sformatf("d%0d c%0d s_we", d, cyc), 64'(s_we[d]), 64'(e_we));
        check($sformatf("d%0d c%0d s_adr", d, cyc), 64'(s_adr[d]), 64'(e_adr));
        check($sformatf("d%0d c%0d m_ack", d, cyc), 64'(m_ack[d]), 64'(e_ack));
        check($sformatf("d%0d c%0d s_do", d, cyc), s_do[d], m_di[wm[d]*64 +: 64]);
        check($sformatf("d%0d c%0d s_sel", d, cyc), 64'(s_sel[d]), 64'(m_sel[wm[d]*8 +: 8]));
        check($sformatf("d%0d c%0d m_do", d, cyc), m_do[d], s_di);
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_step(d, s_eack[d]);
      cyc++;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fmlarbn.md
Name: fmlarbn

Overview:
- Parametrised FML arbiter: N masters onto one FML slave (the SDRAM controller).
- Next generation of the fixed six-port FML arbiter. Adds:
  - configurable channel count;
  - selectable fixed-priority or full round-robin arbitration;
  - a starvation guard that caps consecutive grants to one master;
  - a configurable read-ack delay.
- Sits between the FML clients (VGA, TMU, DMX, CPU cache bridge, ...) and the memory controller.

Parameters:
- fml_depth, 26: FML address width.
- nmasters, 6: number of master ports. Legal range 2..8.
- rr_mode, 0: 0 = master 0 has fixed top priority and the others rotate; 1 = all masters rotate, master 0 included.
- max_run, 8: maximum consecutive eacks granted to one master while another master is requesting. Legal range 1..255.
- rd_delay, 4: cycles from s_eack to the master ack on reads. Legal range 1..15.
- wr_beats, 4: burst length in beats for the write-data mux hold.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- m_adr  in  nmasters*fml_depth  master addresses; master i occupies slice i.
- m_stb  in  nmasters  master strobes.
- m_we  in  nmasters  master write enables.
- m_ack  out  nmasters  per-master ack.
- m_sel  in  nmasters*8  byte selects.
- m_di  in  nmasters*64  write data.
- m_do  out  64  read data; s_di fanned out, common to all masters.
- s_adr  out  fml_depth  slave address.
- s_stb  out  1  slave strobe.
- s_we  out  1  slave write enable.
- s_eack  in  1  slave early ack.
- s_sel  out  8  slave byte selects.
- s_di  in  64  slave read data.
- s_do  out  64  slave write data.
- grant  out  3  current master index, for debug and profiling.

Behaviour:
- Reset (asynchronous, sys_rst_n low):
  - master = 0, wmaster = 0, run counter = 0, all ack channels idle.
  - m_ack = 0. s_stb = 0 unless m_stb[0] is asserted, because the slave mux follows master 0.
- Masked strobe, per channel: stbm[i] = m_stb[i] & ~pend[i].
  - pend[i] sets on eack_i = (master==i) & s_eack.
  - pend[i] clears on the cycle m_ack[i] is asserted.
- Ack timing:
  - Write: m_ack[i] = eack_i, combinational, same cycle as eack.
  - Read: m_ack[i] is asserted exactly rd_delay cycles after eack_i, for 1 cycle. Implemented as a shift register per channel; only one read is outstanding per master.
- Slave control mux (combinational on master):
  - s_adr, s_we = selected master's adr/we.
  - s_stb = stbm[master].
- Re-arbitration point: ~stbm[master] | s_eack. Between points, master is held.
- Candidate search:
  - rr_mode=0: if stbm[0], pick 0 (subject to the starvation guard); else search cyclically from master+1, skipping 0.
  - rr_mode=1: search cyclically from master+1 over all masters.
  - No other requester: stay on the current master.
  - master updates on the next clock edge.
- Starvation guard:
  - run counter increments on each s_eack while the next master equals the current master and any other stbm is asserted; otherwise it resets to 0.
  - When run == max_run-1 and s_eack occurs with another requester present, the current master is excluded from the search for that point. This applies to master 0 in priority mode too.
- Write data mux:
  - On s_we & s_eack, wmaster <= master and a beat counter loads wr_beats-1.
  - s_do/s_sel = m_di/m_sel slices of wmaster.
  - wmaster may only update again after the beat counter reaches 0. Back-to-back write eacks closer than wr_beats are a slave protocol violation; assertion in simulation only.
- Simultaneous events:
  - eack on a read together with another master's stb: switch on the next cycle, and the ack of the previous master still arrives at rd_delay.
  - Reset mid-burst: all pending acks are dropped and no spurious ack is produced after release.
- Index arithmetic: modulo nmasters. Unused grant encodings (>= nmasters) are never reached; a default branch maps to master 0.

Decomposition:
- Shared package fmlarbn_pkg:
  - RR_FIXED0 = 0 and RR_ALL = 1 mode constants;
  - idx_t typedef (3 bits);
  - function next_rr(master, req, exclude, skip0) returning idx_t.
- Sub-module fmlarbn_ack: one instance per channel, holding the pend flag, the rd_delay shift register and the stbm/ack generation.

Test Plan:
- Single master, nmasters=4: m_stb[2] read, eack at t -> m_ack[2] at t+4 only; stbm[2] low over t+1..t+4; grant=2 from the cycle after the request.
- Write from master 1, eack at t, data beats D0..D3 -> s_do = m_di[1] over t+1..t+4; m_ack[1] at t; a master 3 write arbitrated meanwhile does not disturb wmaster before t+4.
- rr_mode=1, masters 0,1,3 continuously requesting with an eack every cycle -> grant sequence 0,1,3,0,1,3.
- rr_mode=0, max_run=3, masters 0 and 2 continuously requesting -> grant 0,0,0,2,0,0,0,2.
- Master 0 drops stb without eack while masters 4 and 5 request -> next grant 1-search from 1 picks 4, and master 0 gets no ack.
- Reset asserted asynchronously 2 cycles after a read eack -> m_ack all 0 and grant=0 immediately; no ack after reset release.
